// File: rtl/wb_cmd_pkg.sv
// Opcodes, status bytes and FSM states shared by the byte-serial Wishbone command master.
// Multi-byte protocol fields are sent MSB first.
package wb_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    localparam logic [7:0] ST_ACK   = 8'h06;
    localparam logic [7:0] ST_NAK   = 8'h15;
    localparam logic [7:0] ST_BAD   = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_e;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Wishbone classic initiator/responder signal bundle.
// The master modport drives the cycle; the slave modport returns data and ack.
interface wb_cmd_master_if;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );

endinterface

// File: rtl/wb_cmd_master.sv
// Byte-stream to Wishbone single-cycle master; cyc rises the cycle after the last command byte, response the cycle after ack/timeout.
// Half-duplex: rx_ready_o drops during BUS/RESP; tx byte held until tx_ready_i; no ack within TIMEOUT cycles returns NAK.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_n_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       rx_ready_o,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_ready_i,
    wb_cmd_master_if.master wbm
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          is_wr_q, is_wr_d;
    logic          more_q, more_d;
    logic          cyc_q, cyc_d;
    logic          rx_rdy_q, rx_rdy_d;
    logic          tx_vld_q, tx_vld_d;
    logic [7:0]    tx_dat_q, tx_dat_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [TW-1:0] to_q, to_d;

    logic rx_fire, tx_fire;

    assign rx_fire = rx_valid_i && rx_rdy_q;
    assign tx_fire = tx_vld_q && tx_ready_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_wr_d  = is_wr_q;
        more_d   = more_q;
        cyc_d    = cyc_q;
        tx_vld_d = tx_vld_q;
        tx_dat_d = tx_dat_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        to_d     = to_q;

        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    cnt_d = 2'd0;
                    if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
                        is_wr_d = (rx_data_i == OP_WRITE);
                        state_d = S_ADDR;
                    end else begin
                        state_d  = S_RESP;
                        tx_vld_d = 1'b1;
                        tx_dat_d = ST_BAD;
                        more_d   = 1'b0;
                    end
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    adr_d = {adr_q[23:0], rx_data_i};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (is_wr_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_BUS;
                            cyc_d   = 1'b1;
                            to_d    = '0;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    dat_d = {dat_q[23:0], rx_data_i};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_BUS;
                        cyc_d   = 1'b1;
                        to_d    = '0;
                    end
                end
            end
            S_BUS: begin
                // Ack is tested before expiry so a late ack on the last cycle still succeeds.
                if (wbm.wbm_ack_i) begin
                    state_d  = S_RESP;
                    cyc_d    = 1'b0;
                    tx_vld_d = 1'b1;
                    tx_dat_d = ST_ACK;
                    more_d   = !is_wr_q;
                    cnt_d    = 2'd0;
                    if (!is_wr_q) begin
                        dat_d = wbm.wbm_dat_i;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d  = S_RESP;
                    cyc_d    = 1'b0;
                    tx_vld_d = 1'b1;
                    tx_dat_d = ST_NAK;
                    more_d   = 1'b0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_RESP: begin
                if (tx_fire) begin
                    if (more_q) begin
                        tx_dat_d = dat_q[31:24];
                        dat_d    = {dat_q[23:0], 8'h00};
                        cnt_d    = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            more_d = 1'b0;
                        end
                    end else begin
                        tx_vld_d = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        rx_rdy_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            is_wr_q  <= 1'b0;
            more_q   <= 1'b0;
            cyc_q    <= 1'b0;
            rx_rdy_q <= 1'b0;
            tx_vld_q <= 1'b0;
            tx_dat_q <= 8'h00;
            adr_q    <= 32'h0;
            dat_q    <= 32'h0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_wr_q  <= is_wr_d;
            more_q   <= more_d;
            cyc_q    <= cyc_d;
            rx_rdy_q <= rx_rdy_d;
            tx_vld_q <= tx_vld_d;
            tx_dat_q <= tx_dat_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            to_q     <= to_d;
        end
    end

    assign rx_ready_o    = rx_rdy_q;
    assign tx_valid_o    = tx_vld_q;
    assign tx_data_o     = tx_dat_q;
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = cyc_q & is_wr_q;
    assign wbm.wbm_sel_o = {4{cyc_q}};
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;

endmodule
